// File: rtl/surf6_fwu_ring_marker_if.sv
// Firmware-update ring handshake bundle: write/mark pulses,
// PS done GPIs, per-buffer status, next buffer and completion count.
interface surf6_fwu_ring_marker_if #(
  parameter int NBUF = 2
);
  localparam int IW = $clog2(NBUF);

  logic [NBUF-1:0] fw_wr_i;
  logic [NBUF-1:0] fw_mark_i;
  logic [NBUF-1:0] ps_fwdone_gpi_i;
  logic [NBUF-1:0] err_clr_i;
  logic [NBUF-1:0] ps_fwupdate_gpo_o;
  logic [NBUF-1:0] fw_pscomplete_o;
  logic [NBUF-1:0] fw_err_o;
  logic [NBUF-1:0] timeout_o;
  logic [IW-1:0]   next_buf_o;
  logic [15:0]     done_count_o;

  modport master (
    output fw_wr_i, fw_mark_i,
    output ps_fwdone_gpi_i, err_clr_i,
    input  ps_fwupdate_gpo_o, fw_pscomplete_o,
    input  fw_err_o, timeout_o,
    input  next_buf_o, done_count_o
  );

  modport slave (
    input  fw_wr_i, fw_mark_i,
    input  ps_fwdone_gpi_i, err_clr_i,
    output ps_fwupdate_gpo_o, fw_pscomplete_o,
    output fw_err_o, timeout_o,
    output next_buf_o, done_count_o
  );
endinterface

// File: rtl/surf6_fwu_ring_marker.sv
// NBUF-buffer firmware ring tracker: per-buffer IDLE/MARKED/COMPLETE,
// synchronised PS done edges, sticky errors, stall timeout, counters.
module surf6_fwu_ring_marker #(
  parameter int NBUF        = 2,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_W   = 24,
  parameter int ORDERED     = 1
) (
  input logic wb_clk_i,
  input logic wb_rstn_i,
  surf6_fwu_ring_marker_if.slave bus
);
  localparam int IW = $clog2(NBUF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MARKED = 2'd1,
    S_CMPL   = 2'd2
  } st_t;

  st_t                 st_q  [NBUF];
  st_t                 st_d  [NBUF];
  logic [TIMEOUT_W-1:0] cnt_q [NBUF];
  logic [TIMEOUT_W-1:0] cnt_d [NBUF];
  logic [NBUF-1:0]     sync_q [SYNC_STAGES];
  logic [NBUF-1:0]     hist_q;
  logic [NBUF-1:0]     err_q, err_d;
  logic [NBUF-1:0]     set_err;
  logic [NBUF-1:0]     done_edge;
  logic [IW-1:0]       nb_q, nb_d;
  logic [15:0]         dc_q, dc_d;
  logic                adv;

  assign done_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      hist_q <= '0;
      for (int k = 0; k < NBUF; k++) begin
        st_q[k]  <= S_IDLE;
        cnt_q[k] <= '0;
      end
      err_q <= '0;
      nb_q  <= '0;
      dc_q  <= '0;
    end else begin
      sync_q[0] <= bus.ps_fwdone_gpi_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
      for (int k = 0; k < NBUF; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      err_q <= err_d;
      nb_q  <= nb_d;
      dc_q  <= dc_d;
    end
  end

  always_comb begin
    nb_d    = nb_q;
    dc_d    = dc_q;
    adv     = 1'b0;
    set_err = '0;
    for (int k = 0; k < NBUF; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = cnt_q[k];
      unique case (st_q[k])
        S_MARKED: begin
          if (done_edge[k]) begin
            st_d[k] = S_CMPL;
            dc_d    = dc_d + 16'd1;
            // Out-of-order completion still frees the buffer.
            if (ORDERED != 0) begin
              if (IW'(k) == nb_q) adv = 1'b1;
              else set_err[k] = 1'b1;
            end
          end
          if (bus.fw_wr_i[k] || bus.fw_mark_i[k])
            set_err[k] = 1'b1;
          if (!(&cnt_q[k]))
            cnt_d[k] = cnt_q[k] + 1'b1;
        end
        S_IDLE, S_CMPL: begin
          if (bus.fw_mark_i[k]) begin
            st_d[k]  = S_MARKED;
            cnt_d[k] = '0;
          end else if (bus.fw_wr_i[k] && st_q[k] == S_CMPL) begin
            st_d[k] = S_IDLE;
          end
        end
        default: st_d[k] = S_IDLE;
      endcase
    end
    err_d = set_err | (err_q & ~bus.err_clr_i);
    if (adv)
      nb_d = (nb_q == IW'(NBUF-1)) ? '0 : nb_q + IW'(1);
  end

  always_comb begin
    for (int k = 0; k < NBUF; k++) begin
      bus.ps_fwupdate_gpo_o[k] = (st_q[k] == S_MARKED);
      bus.fw_pscomplete_o[k]   = (st_q[k] == S_CMPL);
      bus.timeout_o[k]         = (st_q[k] == S_MARKED) && (&cnt_q[k]);
    end
    bus.fw_err_o     = err_q;
    bus.next_buf_o   = nb_q;
    bus.done_count_o = dc_q;
  end
endmodule

// File: tb/tb_surf6_fwu_ring_marker.sv
// Bench for surf6_fwu_ring_marker: directed plan steps then random
// traffic, all checked against a cycle-level behavioural model.
module tb_surf6_fwu_ring_marker;
  localparam int NB  = 4;
  localparam int SS  = 3;
  localparam int TW  = 4;
  localparam int ORD = 1;
  localparam int TMAX = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  surf6_fwu_ring_marker_if #(.NBUF(NB)) bus ();

  surf6_fwu_ring_marker #(
    .NBUF(NB), .SYNC_STAGES(SS),
    .TIMEOUT_W(TW), .ORDERED(ORD)
  ) dut (
    .wb_clk_i (clk),
    .wb_rstn_i(rst_n),
    .bus      (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 handed to PS, 2 read out.
  int st [NB];
  int mcyc [NB];
  logic [NB-1:0] m_err;
  int nb;
  int dcnt;
  int cyc;
  logic [NB-1:0] smp [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      st[k] = 0;
      mcyc[k] = 0;
    end
    m_err = '0;
    nb = 0;
    dcnt = 0;
    cyc = 0;
    smp.delete();
    for (int i = 0; i <= SS; i++) smp.push_back('0);
  endtask

  // smp holds samples from edges m-SS-1 .. m-1, oldest first.
  task automatic model_edge(input logic [NB-1:0] wr,
                            input logic [NB-1:0] mk,
                            input logic [NB-1:0] gpi,
                            input logic [NB-1:0] clr);
    logic [NB-1:0] e;
    logic [NB-1:0] set;
    bit adv;
    e = smp[1] & ~smp[0];
    void'(smp.pop_front());
    smp.push_back(gpi);
    cyc++;
    set = '0;
    adv = 0;
    for (int k = 0; k < NB; k++) begin
      if (st[k] == 1) begin
        if (e[k]) begin
          st[k] = 2;
          dcnt = (dcnt + 1) % 65536;
          if (ORD != 0) begin
            if (k == nb) adv = 1;
            else set[k] = 1'b1;
          end
        end
        if (wr[k] || mk[k]) set[k] = 1'b1;
      end else if (mk[k]) begin
        st[k] = 1;
        mcyc[k] = cyc;
      end else if (wr[k] && st[k] == 2) begin
        st[k] = 0;
      end
      if (set[k]) m_err[k] = 1'b1;
      else if (clr[k]) m_err[k] = 1'b0;
    end
    if (adv) nb = (nb + 1) % NB;
  endtask

  task automatic check_all(input string tag);
    logic [NB-1:0] eg, ec, et;
    for (int k = 0; k < NB; k++) begin
      eg[k] = (st[k] == 1);
      ec[k] = (st[k] == 2);
      et[k] = (st[k] == 1) && (cyc - mcyc[k] >= TMAX);
    end
    chk({tag, ".gpo"}, 32'(bus.ps_fwupdate_gpo_o), 32'(eg));
    chk({tag, ".cmpl"}, 32'(bus.fw_pscomplete_o), 32'(ec));
    chk({tag, ".err"}, 32'(bus.fw_err_o), 32'(m_err));
    chk({tag, ".tmo"}, 32'(bus.timeout_o), 32'(et));
    chk({tag, ".nbuf"}, 32'(bus.next_buf_o), 32'(nb));
    chk({tag, ".dcnt"}, 32'(bus.done_count_o), 32'(dcnt));
  endtask

  task automatic step(input string tag = "step");
    @(posedge clk);
    model_edge(bus.fw_wr_i, bus.fw_mark_i,
               bus.ps_fwdone_gpi_i, bus.err_clr_i);
    #1;
    bus.fw_wr_i = '0;
    bus.fw_mark_i = '0;
    bus.err_clr_i = '0;
    check_all(tag);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.fw_wr_i = '0;
    bus.fw_mark_i = '0;
    bus.ps_fwdone_gpi_i = '0;
    bus.err_clr_i = '0;
    do_reset();

    // In-order completion of all four buffers.
    bus.fw_mark_i = 4'hF;
    step("mark_all");
    for (int k = 0; k < NB; k++) begin
      bus.ps_fwdone_gpi_i[k] = 1'b1;
      repeat (SS) step("ord");
      chk("ord.gpo_hold", 32'(bus.ps_fwupdate_gpo_o[k]), 32'd1);
      step("ord");
      chk("ord.cmpl_rise", 32'(bus.fw_pscomplete_o[k]), 32'd1);
    end
    chk("ord.count", 32'(bus.done_count_o), 32'd4);
    chk("ord.next", 32'(bus.next_buf_o), 32'd0);
    chk("ord.noerr", 32'(bus.fw_err_o), 32'd0);
    bus.ps_fwdone_gpi_i = '0;
    repeat (SS + 2) step("gpi_low");

    // Refill then re-mark buffer 1.
    bus.fw_wr_i[1] = 1'b1;
    step("refill");
    chk("refill.cmpl1", 32'(bus.fw_pscomplete_o[1]), 32'd0);
    bus.fw_mark_i[1] = 1'b1;
    step("remark");
    chk("remark.gpo1", 32'(bus.ps_fwupdate_gpo_o[1]), 32'd1);

    // Protocol errors on buffer 2 and clear priority.
    bus.fw_mark_i[2] = 1'b1;
    step("mark2");
    bus.fw_wr_i[2] = 1'b1;
    step("wr_marked");
    chk("wr_marked.err2", 32'(bus.fw_err_o[2]), 32'd1);
    chk("wr_marked.gpo2", 32'(bus.ps_fwupdate_gpo_o[2]), 32'd1);
    bus.fw_mark_i[2] = 1'b1;
    bus.err_clr_i[2] = 1'b1;
    step("set_vs_clr");
    chk("set_vs_clr.err2", 32'(bus.fw_err_o[2]), 32'd1);
    bus.err_clr_i[2] = 1'b1;
    step("clr");
    chk("clr.err2", 32'(bus.fw_err_o[2]), 32'd0);

    // Out-of-order completion of buffer 3.
    bus.fw_mark_i[3] = 1'b1;
    step("mark3");
    bus.ps_fwdone_gpi_i[3] = 1'b1;
    repeat (SS + 1) step("ooo");
    chk("ooo.cmpl3", 32'(bus.fw_pscomplete_o[3]), 32'd1);
    chk("ooo.err3", 32'(bus.fw_err_o[3]), 32'd1);
    chk("ooo.next", 32'(bus.next_buf_o), 32'd0);
    bus.ps_fwdone_gpi_i = '0;
    step("ooo_low");

    // Stall timeout on buffer 0.
    do_reset();
    bus.fw_mark_i[0] = 1'b1;
    step("tmo_mark");
    repeat (TMAX - 1) step("tmo_wait");
    chk("tmo.before", 32'(bus.timeout_o[0]), 32'd0);
    step("tmo_edge");
    chk("tmo.rise", 32'(bus.timeout_o[0]), 32'd1);
    bus.ps_fwdone_gpi_i[0] = 1'b1;
    repeat (SS) step("tmo_done");
    chk("tmo.held", 32'(bus.timeout_o[0]), 32'd1);
    step("tmo_done");
    chk("tmo.drop", 32'(bus.timeout_o[0]), 32'd0);
    chk("tmo.gpo0", 32'(bus.ps_fwupdate_gpo_o[0]), 32'd0);

    // GPIs held high through reset.
    bus.ps_fwdone_gpi_i = 4'hF;
    repeat (SS + 2) step("gpi_hi");
    do_reset();
    repeat (SS + 3) step("gpi_hi_post");
    chk("gpi_hi.err", 32'(bus.fw_err_o), 32'd0);
    chk("gpi_hi.cnt", 32'(bus.done_count_o), 32'd0);
    chk("gpi_hi.cmpl", 32'(bus.fw_pscomplete_o), 32'd0);
    bus.ps_fwdone_gpi_i = '0;
    repeat (SS + 2) step("gpi_lo");

    // Reset while marked drops gpo asynchronously.
    bus.fw_mark_i[1] = 1'b1;
    step("pre_rst");
    chk("pre_rst.gpo1", 32'(bus.ps_fwupdate_gpo_o[1]), 32'd1);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NB; k++) begin
        bus.fw_wr_i[k]   = ($urandom_range(0, 7) == 0);
        bus.fw_mark_i[k] = ($urandom_range(0, 5) == 0);
        bus.err_clr_i[k] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 4) == 0)
          bus.ps_fwdone_gpi_i[k] = ~bus.ps_fwdone_gpi_i[k];
      end
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/surf6_fwu_ring_marker.md
# surf6_fwu_ring_marker

Single-clock, parametrised tracker for the firmware-update buffer ring between the command/URAM write path and the PS. It generalises the fixed A/B half-buffer marker to NBUF buffers, each with its own mark/done handshake. It adds sticky protocol-error flags, a per-buffer PS-stall timeout, optional in-order completion checking and a completion counter. Upstream flags are already in wb_clk_i; PS GPIs are asynchronous and synchronised inside the block.

## Interface
- NBUF, 2, buffer count (2..8)
- SYNC_STAGES, 3, GPI synchroniser depth (>=2)
- TIMEOUT_W, 24, width of per-buffer stall counter
- ORDERED, 1, 1 = PS must complete buffers in index order 0,1,..,NBUF-1,0,..
- wb_clk_i  in  1  sole clock
- wb_rstn_i  in  1  asynchronous, active-low reset
- fw_wr_i  in  NBUF  1-cycle pulse: write into buffer k
- fw_mark_i  in  NBUF  1-cycle pulse: buffer k handed to PS
- ps_fwdone_gpi_i  in  NBUF  async PS level; rising edge = buffer k read out
- ps_fwupdate_gpo_o  out  NBUF  buffer k marked, awaiting PS
- fw_pscomplete_o  out  NBUF  buffer k read out by PS, free to refill
- fw_err_o  out  NBUF  sticky protocol error on buffer k
- err_clr_i  in  NBUF  1-cycle pulse: clear fw_err_o[k]
- timeout_o  out  NBUF  buffer k marked for 2^TIMEOUT_W-1 cycles
- next_buf_o  out  $clog2(NBUF)  next buffer expected from PS (ORDERED)
- done_count_o  out  16  total completions, wraps modulo 2^16

## Operation
- Per-buffer state machine: IDLE, MARKED, COMPLETE. ps_fwupdate_gpo_o[k] = (MARKED). fw_pscomplete_o[k] = (COMPLETE).
- IDLE: mark -> MARKED; wr -> stay IDLE.
- COMPLETE: wr -> IDLE; mark -> MARKED. Mark and wr in the same cycle -> MARKED.
- MARKED: done edge -> COMPLETE. wr -> set err[k] and stay MARKED. mark -> set err[k] and stay MARKED. A done edge in the same cycle as wr or mark -> COMPLETE, and err[k] is still set.
- Done edge in IDLE/COMPLETE: ignored, no error. This also covers a PS GPI held high through reset.
- GPI sync: an SYNC_STAGES-flop chain plus one history flop, all reset to 0. Edge = last stage 1 and history 0.
- ORDERED=1: a done edge on k != next_buf_o still completes k and sets err[k]; next_buf_o unchanged. A done edge on next_buf_o advances next_buf_o by 1 mod NBUF. ORDERED=0: next_buf_o held 0, no ordering errors.
- fw_err_o[k]: set has priority over err_clr_i[k] in the same cycle.
- Timeout: counter[k] clears on entry to MARKED and increments each MARKED cycle. It saturates at all-ones. timeout_o[k] = MARKED and counter[k] all-ones. timeout_o[k] drops on leaving MARKED.
- done_count_o adds the number of MARKED->COMPLETE transitions in that cycle (popcount, 0..NBUF).

## Timing
- Reset (async assert, sync-safe deassert): all states IDLE; all outputs 0; next_buf_o = 0; counters 0.
- fw_mark_i/fw_wr_i pulse at edge n -> outputs change at edge n+1 (registered, 1-cycle latency).
- GPI rising, first sampled high at edge n -> gpo falls and pscomplete rises at edge n+SYNC_STAGES. done_count_o and next_buf_o update on the same edge.
- Timeout: mark at edge n -> timeout_o rises at edge n+2^TIMEOUT_W-1 if still MARKED.
- No combinational input-to-output paths.

## Test plan
- NBUF=4, ORDERED=1: mark 0..3; raise GPI 0..3 in order -> each gpo falls and pscomplete rises SYNC_STAGES cycles after sampling; done_count_o=4; next_buf_o returns to 0; fw_err_o=0.
- Complete buffer 1, then pulse fw_wr_i[1] -> fw_pscomplete_o[1] falls next cycle. Then fw_mark_i[1] -> gpo[1]=1.
- Buffer 2 MARKED, pulse fw_wr_i[2] -> fw_err_o[2]=1 and gpo[2] stays 1. Pulse err_clr_i[2] in the same cycle as a second fw_mark_i[2] -> err stays 1. A lone err_clr_i[2] -> 0.
- ORDERED=1, next_buf_o=0: GPI edge on buffer 3 while MARKED -> pscomplete[3]=1, fw_err_o[3]=1, next_buf_o=0.
- TIMEOUT_W=4: mark 0 with no GPI -> timeout_o[0]=1 at 15 cycles. GPI edge -> timeout_o[0]=0 when gpo falls.
- GPI held 1 across wb_rstn_i low: outputs 0 during reset and after release, no error, done_count_o=0. Reset asserted mid-MARKED -> gpo drops immediately.
